// File: rtl/silent_step_scheduler.sv
// Silent-mode sweeper: on each UPDATE, moves every transducer's duty/phase toward its target by at most STEP.
// Optional macro SILENT_BYPASS_EN adds a BYPASS input that loads targets directly while still tracking them.
module silent_step_scheduler #(
    parameter int NUM_TRANS = 249,
    parameter int ADDR_W    = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              UPDATE,
    input  logic [7:0]        STEP,
`ifdef SILENT_BYPASS_EN
    input  logic              BYPASS,
`endif
    output logic [ADDR_W-1:0] TGT_ADDR,
    input  logic [15:0]       TGT_DATA,
    output logic              OUT_VALID,
    output logic [ADDR_W-1:0] OUT_IDX,
    output logic [7:0]        OUT_DUTY,
    output logic [7:0]        OUT_PHASE,
    output logic              BUSY,
    output logic              OVERRUN,
    input  logic              CLR_OVERRUN
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_WR   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TRANS - 1);

    // Linear step that clamps at the target instead of overshooting or wrapping.
    function automatic logic [7:0] step_duty(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] diff;
        logic [8:0] mag;
        logic [7:0] res;
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[8] ? (9'd0 - diff) : diff;
        if (mag <= {1'b0, step}) begin
            res = tgt;
        end else if (diff[8]) begin
            res = cur - step;
        end else begin
            res = cur + step;
        end
        return res;
    endfunction

    // Circular step along the shorter arc; a half-turn distance moves forward.
    function automatic logic [7:0] step_phase(input logic [7:0] cur, input logic [7:0] tgt,
                                              input logic [7:0] step);
        logic [7:0] d;
        logic [7:0] back;
        logic [7:0] mv;
        logic [7:0] res;
        d    = tgt - cur;
        back = 8'd0 - d;
        mv   = 8'd0;
        if (d == 8'd0) begin
            res = cur;
        end else if (d <= 8'd128) begin
            mv  = (d < step) ? d : step;
            res = cur + mv;
        end else begin
            mv  = (back < step) ? back : step;
            res = cur - mv;
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [ADDR_W-1:0]   idx_nxt_s;
    logic                accept_s;
    logic                mem_we_s;
    logic [15:0]         mem_wdata_s;
    logic [15:0]         cur_mem [0:NUM_TRANS-1];
    logic [15:0]         cur_rd_r;
    logic [7:0]          step_r;
    logic [7:0]          new_duty_s;
    logic [7:0]          new_phase_s;
    logic                busy_r;
    logic                ovr_r;
    logic [ADDR_W-1:0]   tgt_addr_r;
    logic                out_valid_r;
    logic [ADDR_W-1:0]   out_idx_r;
    logic [7:0]          out_duty_r;
    logic [7:0]          out_phase_r;

`ifdef SILENT_BYPASS_EN
    logic                bypass_r;

    // Bypass option captured with STEP at sweep start.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bypass_r <= 1'b0;
        end else if (accept_s) begin
            bypass_r <= BYPASS;
        end
    end

    assign new_duty_s  = bypass_r ? TGT_DATA[15:8] : step_duty(cur_rd_r[15:8], TGT_DATA[15:8], step_r);
    assign new_phase_s = bypass_r ? TGT_DATA[7:0]  : step_phase(cur_rd_r[7:0], TGT_DATA[7:0], step_r);
`else
    assign new_duty_s  = step_duty(cur_rd_r[15:8], TGT_DATA[15:8], step_r);
    assign new_phase_s = step_phase(cur_rd_r[7:0], TGT_DATA[7:0], step_r);
`endif

    // Next-state, index and current-RAM write control.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        accept_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 16'h0000;
        case (state_r)
            ST_INIT: begin
                mem_we_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = '0;
                end else begin
                    idx_nxt_s = idx_r + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (UPDATE) begin
                    state_nxt_s = ST_RD;
                    idx_nxt_s   = '0;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = {new_duty_s, new_phase_s};
                state_nxt_s = ST_WR;
            end
            ST_WR: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_RD;
                    idx_nxt_s   = idx_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // State, index and busy flag; busy is high whenever the FSM is anywhere but IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_INIT;
            idx_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Current-value RAM write port; contents survive reset and are cleared only by INIT.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            cur_mem[idx_r] <= mem_wdata_s;
        end
    end

    // Current-value read, launched in RD alongside the target address.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_rd_r <= 16'h0000;
        end else if (state_r == ST_RD) begin
            cur_rd_r <= cur_mem[idx_r];
        end
    end

    // STEP is frozen for the whole sweep.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_r <= 8'd0;
        end else if (accept_s) begin
            step_r <= STEP;
        end
    end

    // Target address is presented for the RD cycle of each transducer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tgt_addr_r <= '0;
        end else if (state_nxt_s == ST_RD) begin
            tgt_addr_r <= idx_nxt_s;
        end
    end

    // Result registered at the end of WAIT so it is visible during WR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
            out_duty_r  <= 8'd0;
            out_phase_r <= 8'd0;
        end else begin
            out_valid_r <= (state_r == ST_WAIT);
            if (state_r == ST_WAIT) begin
                out_idx_r   <= idx_r;
                out_duty_r  <= new_duty_s;
                out_phase_r <= new_phase_s;
            end
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovr_r <= 1'b0;
        end else if (UPDATE && busy_r) begin
            ovr_r <= 1'b1;
        end else if (CLR_OVERRUN) begin
            ovr_r <= 1'b0;
        end
    end

    assign TGT_ADDR  = tgt_addr_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_IDX   = out_idx_r;
    assign OUT_DUTY  = out_duty_r;
    assign OUT_PHASE = out_phase_r;
    assign BUSY      = busy_r;
    assign OVERRUN   = ovr_r;

endmodule

// File: tb/tb_silent_step_scheduler.sv
// Bench for silent_step_scheduler: directed table, test-plan sequences and randomized sweeps vs. an arithmetic model.
module tb_silent_step_scheduler;
    localparam int N  = 249;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          UPDATE = 1'b0;
    logic [7:0]    STEP = 8'd0;
    logic          CLR_OVERRUN = 1'b0;
`ifdef SILENT_BYPASS_EN
    logic          BYPASS = 1'b0;
`endif
    logic [AW-1:0] TGT_ADDR;
    logic [15:0]   TGT_DATA = 16'h0000;
    logic          OUT_VALID;
    logic [AW-1:0] OUT_IDX;
    logic [7:0]    OUT_DUTY;
    logic [7:0]    OUT_PHASE;
    logic          BUSY;
    logic          OVERRUN;

    silent_step_scheduler #(.NUM_TRANS(N), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .STEP(STEP),
`ifdef SILENT_BYPASS_EN
        .BYPASS(BYPASS),
`endif
        .TGT_ADDR(TGT_ADDR), .TGT_DATA(TGT_DATA), .OUT_VALID(OUT_VALID), .OUT_IDX(OUT_IDX),
        .OUT_DUTY(OUT_DUTY), .OUT_PHASE(OUT_PHASE), .BUSY(BUSY), .OVERRUN(OVERRUN),
        .CLR_OVERRUN(CLR_OVERRUN)
    );

    always #5 CLK = ~CLK;

    int tgt_d [N];
    int tgt_p [N];
    int cur_d [N];
    int cur_p [N];
    int exp_d [N];
    int exp_p [N];
    int got_d [N];
    int got_p [N];

    // Target BRAM: one-cycle read latency.
    always @(posedge CLK) TGT_DATA <= {8'(tgt_d[TGT_ADDR]), 8'(tgt_p[TGT_ADDR])};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int ref_duty(input int cur, input int tgt, input int step);
        int diff;
        diff = tgt - cur;
        if (diff > step) return cur + step;
        if (diff < -step) return cur - step;
        return tgt;
    endfunction

    function automatic int ref_phase(input int cur, input int tgt, input int step);
        int d;
        int mv;
        d = ((tgt - cur) % 256 + 256) % 256;
        if (d == 0) return cur;
        if (d <= 128) mv = (d < step) ? d : step;
        else mv = -(((256 - d) < step) ? (256 - d) : step);
        return ((cur + mv) % 256 + 256) % 256;
    endfunction

    task automatic set_targets(input int d, input int p);
        for (int i = 0; i < N; i++) begin
            tgt_d[i] = d;
            tgt_p[i] = p;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_init(input int upd_k);
        int e_busy;
        int e_v;
        e_busy = 0;
        e_v = 0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int k = 0; k <= N; k++) begin
            if (BUSY !== (k < N)) e_busy++;
            if (OUT_VALID !== 1'b0) e_v++;
            if (k == upd_k) UPDATE = 1'b1;
            tick();
            UPDATE = 1'b0;
        end
        check("init_busy_window", e_busy, 0);
        check("init_no_valid", e_v, 0);
        for (int i = 0; i < N; i++) begin
            cur_d[i] = 0;
            cur_p[i] = 0;
        end
    endtask

    task automatic run_sweep(input int step, input bit byp, input bit clr0, input int inj_k, input bit inj_clr);
        int e_valid;
        int e_busy;
        int e_val;
        int nvalid;
        int idx;
        bit expv;
        e_valid = 0;
        e_busy = 0;
        e_val = 0;
        nvalid = 0;
        for (int i = 0; i < N; i++) begin
            if (byp) begin
                exp_d[i] = tgt_d[i];
                exp_p[i] = tgt_p[i];
            end else begin
                exp_d[i] = ref_duty(cur_d[i], tgt_d[i], step);
                exp_p[i] = ref_phase(cur_p[i], tgt_p[i], step);
            end
        end
        STEP = 8'(step);
        UPDATE = 1'b1;
        CLR_OVERRUN = clr0;
`ifdef SILENT_BYPASS_EN
        BYPASS = byp;
`endif
        tick();
        UPDATE = 1'b0;
        CLR_OVERRUN = 1'b0;
        STEP = 8'($urandom);
`ifdef SILENT_BYPASS_EN
        BYPASS = ~byp;
`endif
        for (int k = 1; k <= 3 * N + 1; k++) begin
            expv = (k % 3 == 0) && (k <= 3 * N);
            if (OUT_VALID !== expv) e_valid++;
            if (expv && OUT_VALID === 1'b1) begin
                idx = k / 3 - 1;
                nvalid++;
                if (OUT_IDX !== 8'(idx) || OUT_DUTY !== 8'(exp_d[idx]) || OUT_PHASE !== 8'(exp_p[idx]))
                    e_val++;
                got_d[idx] = int'(OUT_DUTY);
                got_p[idx] = int'(OUT_PHASE);
            end
            if (BUSY !== (k <= 3 * N)) e_busy++;
            if (k == inj_k) begin
                UPDATE = 1'b1;
                CLR_OVERRUN = inj_clr;
            end
            tick();
            UPDATE = 1'b0;
            CLR_OVERRUN = 1'b0;
        end
        check("sweep_valid_pattern", e_valid, 0);
        check("sweep_busy_window", e_busy, 0);
        check("sweep_values", e_val, 0);
        check("sweep_valid_count", nvalid, N);
        for (int i = 0; i < N; i++) begin
            cur_d[i] = exp_d[i];
            cur_p[i] = exp_p[i];
        end
    endtask

    typedef struct {
        int cd; int cp; int td; int tp; int st; int ed; int ep;
    } vec_t;
    vec_t tbl [12];

    initial begin
        bit found;
        tbl[0]  = '{0,   0,   200, 10,  4,   4,   4};
        tbl[1]  = '{100, 250, 98,  5,   8,   98,  2};
        tbl[2]  = '{0,   250, 0,   5,   4,   0,   254};
        tbl[3]  = '{0,   254, 0,   5,   4,   0,   2};
        tbl[4]  = '{0,   2,   0,   5,   4,   0,   5};
        tbl[5]  = '{0,   0,   0,   130, 4,   0,   252};
        tbl[6]  = '{0,   0,   0,   128, 4,   0,   4};
        tbl[7]  = '{255, 0,   0,   0,   8,   247, 0};
        tbl[8]  = '{0,   0,   255, 0,   255, 255, 0};
        tbl[9]  = '{10,  20,  200, 200, 0,   10,  20};
        tbl[10] = '{50,  100, 52,  99,  3,   52,  99};
        tbl[11] = '{0,   200, 0,   72,  5,   0,   205};

        set_targets(200, 10);
        RST_N = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        check("reset_values", {OUT_VALID, OUT_IDX, OUT_DUTY, OUT_PHASE, TGT_ADDR, BUSY, OVERRUN},
              {1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0});

        do_init(10);
        check("overrun_during_init", OVERRUN, 1);
        CLR_OVERRUN = 1'b1;
        tick();
        CLR_OVERRUN = 1'b0;
        check("overrun_cleared", OVERRUN, 0);

        for (int s = 1; s <= 51; s++) begin
            run_sweep(4, 1'b0, 1'b0, 0, 1'b0);
            if (s == 1) begin
                check("first_sweep_duty0", got_d[0], 4);
                check("first_sweep_phase0", got_p[0], 4);
                check("first_sweep_duty_last", got_d[N-1], 4);
                check("first_sweep_phase_last", got_p[N-1], 4);
            end
            if (s == 3) check("phase_settled_sweep3", got_p[100], 10);
            if (s >= 50) check("duty_reaches_200", got_d[200], 200);
        end

        run_sweep(4, 1'b0, 1'b0, 100, 1'b0);
        check("overrun_mid_sweep", OVERRUN, 1);
        run_sweep(4, 1'b0, 1'b1, 0, 1'b0);
        check("clear_with_idle_update", OVERRUN, 0);
        run_sweep(4, 1'b0, 1'b0, 100, 1'b1);
        check("overrun_set_beats_clear", OVERRUN, 1);
        CLR_OVERRUN = 1'b1;
        tick();
        CLR_OVERRUN = 1'b0;

        STEP = 8'd4;
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 3 * N; k++) begin
            if (OUT_VALID === 1'b1 && OUT_IDX === 8'd57) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reached_idx57", found, 1);
        check("pre_reset_duty", OUT_DUTY, 200);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_outputs", {OUT_VALID, OUT_IDX, OUT_DUTY, OUT_PHASE, TGT_ADDR, BUSY, OVERRUN},
              {1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0});
        do_init(-1);
        run_sweep(4, 1'b0, 1'b0, 0, 1'b0);
        check("post_reset_duty57", got_d[57], 4);
        check("post_reset_phase57", got_p[57], 4);

        for (int r = 0; r < 12; r++) begin
            set_targets(tbl[r].cd, tbl[r].cp);
            run_sweep(255, 1'b0, 1'b0, 0, 1'b0);
            set_targets(tbl[r].td, tbl[r].tp);
            run_sweep(tbl[r].st, 1'b0, 1'b0, 0, 1'b0);
            check($sformatf("table%0d_duty", r), got_d[0], tbl[r].ed);
            check($sformatf("table%0d_phase", r), got_p[N-1], tbl[r].ep);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                tgt_d[i] = int'($urandom_range(0, 255));
                tgt_p[i] = int'($urandom_range(0, 255));
            end
            run_sweep((r % 2 == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 255)),
                      1'b0, 1'b0, 0, 1'b0);
        end

`ifdef SILENT_BYPASS_EN
        set_targets(255, 128);
        run_sweep(1, 1'b1, 1'b0, 0, 1'b0);
        check("bypass_duty", got_d[0], 255);
        check("bypass_phase", got_p[0], 128);
        set_targets(0, 128);
        run_sweep(1, 1'b0, 1'b0, 0, 1'b0);
        check("after_bypass_duty", got_d[0], 254);
        check("after_bypass_phase", got_p[0], 128);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
